// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin mux arbiter.
// State encoding, requester indices and datapath widths.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int DW    = 3;
  localparam int IW    = 2;

  localparam logic [IW-1:0] IDX_A = 2'd0;
  localparam logic [IW-1:0] IDX_B = 2'd1;
  localparam logic [IW-1:0] IDX_C = 2'd2;
  localparam logic [IW-1:0] IDX_D = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx2oh(
    input logic [IW-1:0] i_idx
  );
    idx2oh = N_REQ'(1) << i_idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/grant/data bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_mux_arbiter_if;
  import rr_mux_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [DW-1:0]    a;
  logic [DW-1:0]    b;
  logic [DW-1:0]    c;
  logic [DW-1:0]    d;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    se;
  logic             en;
  logic [DW-1:0]    y;

  modport master (
    output req, a, b, c, d,
    input  gnt, se, en, y
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, se, en, y
  );

endinterface

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority picker: first requester at or after i_ptr,
// skipping any index set in i_excl.
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  input  logic [N_REQ-1:0] i_excl,
  output logic             o_found,
  output logic [IW-1:0]    o_idx
);

  logic [N_REQ-1:0] w_cand;
  logic [IW-1:0]    w_pos;

  assign w_cand = i_req & ~i_excl;

  // Walk offsets high to low so the nearest candidate wins last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    w_pos   = i_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = i_ptr + IW'(k);
      if (w_cand[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with per-owner quantum and
// a shared output mux driven by the registered select.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int QUANTUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  rr_mux_arbiter_if.slave   bus
);

  localparam logic [3:0] Q = 4'(QUANTUM);

  state_t           r_state;
  state_t           w_state_nx;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_ptr_nx;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nx;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nx;
  logic [IW-1:0]    r_se;
  logic [IW-1:0]    w_se_nx;
  logic             r_en;
  logic             w_en_nx;

  logic             w_own;
  logic             w_hold;
  logic             w_busy;
  logic [IW-1:0]    w_pick_ptr;
  logic [N_REQ-1:0] w_excl;
  logic             w_found;
  logic [IW-1:0]    w_idx;
  logic [DW-1:0]    w_y;

  assign w_busy = (r_state == ST_GRANT);
  assign w_own  = bus.req[r_se];
  assign w_hold = w_busy && w_own && (r_cnt < Q);

  // Once an owner lets go, priority starts just past it.
  assign w_pick_ptr = w_busy ? r_se + 2'd1 : r_ptr;
  assign w_excl     = (w_busy && !w_own) ? idx2oh(r_se) : '0;

  rr_pick u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_pick_ptr),
    .i_excl  (w_excl),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_se    <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
      r_gnt   <= w_gnt_nx;
      r_se    <= w_se_nx;
      r_en    <= w_en_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_gnt_nx   = r_gnt;
    w_se_nx    = r_se;
    w_en_nx    = r_en;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nx = ST_GRANT;
          w_se_nx    = w_idx;
          w_gnt_nx   = idx2oh(w_idx);
          w_en_nx    = 1'b1;
          w_cnt_nx   = 4'd1;
        end
      end
      ST_GRANT: begin
        if (w_hold) begin
          w_cnt_nx = r_cnt + 4'd1;
        end else begin
          w_ptr_nx = w_pick_ptr;
          if (w_found) begin
            w_se_nx  = w_idx;
            w_gnt_nx = idx2oh(w_idx);
            w_en_nx  = 1'b1;
            w_cnt_nx = 4'd1;
          end else begin
            w_state_nx = ST_IDLE;
            w_gnt_nx   = '0;
            w_en_nx    = 1'b0;
            w_cnt_nx   = '0;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_y = '0;
    if (r_en) begin
      unique case (r_se)
        IDX_A: w_y = bus.a;
        IDX_B: w_y = bus.b;
        IDX_C: w_y = bus.c;
        IDX_D: w_y = bus.d;
        default: w_y = '0;
      endcase
    end
  end

  assign bus.gnt = r_gnt;
  assign bus.se  = r_se;
  assign bus.en  = r_en;
  assign bus.y   = w_y;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench: two arbiters (quantum 4 and 1) on shared stimulus,
// checked against a queue-free ownership model.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_mux_arbiter_if if4 ();
  rr_mux_arbiter_if if1 ();

  rr_mux_arbiter #(.QUANTUM(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  rr_mux_arbiter #(.QUANTUM(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m_own [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_se  [2];
  int qv    [2];
  logic [2:0] dv [4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input int p, input logic [3:0] r,
                              input int excl);
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (p + off) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k] = -1;
      m_ptr[k] = 0;
      m_cnt[k] = 0;
      m_se[k]  = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    for (int k = 0; k < 2; k++) begin
      int w;
      if (m_own[k] < 0) begin
        w = scan(m_ptr[k], r, -1);
        if (w >= 0) begin
          m_own[k] = w; m_se[k] = w; m_cnt[k] = 1;
        end
      end else if (r[m_own[k]] && m_cnt[k] < qv[k]) begin
        m_cnt[k]++;
      end else begin
        m_ptr[k] = (m_own[k] + 1) % 4;
        w = scan(m_ptr[k], r, r[m_own[k]] ? -1 : m_own[k]);
        if (w >= 0) begin
          m_own[k] = w; m_se[k] = w; m_cnt[k] = 1;
        end else begin
          m_own[k] = -1; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] g;
      logic [1:0] s;
      logic       e;
      logic [2:0] yy;
      logic [3:0] eg;
      logic [2:0] ey;
      g  = (k == 0) ? if4.gnt : if1.gnt;
      s  = (k == 0) ? if4.se  : if1.se;
      e  = (k == 0) ? if4.en  : if1.en;
      yy = (k == 0) ? if4.y   : if1.y;
      eg = (m_own[k] >= 0) ? 4'(1 << m_own[k]) : 4'b0000;
      ey = (m_own[k] >= 0) ? dv[m_se[k]] : 3'b000;
      chk($sformatf("gnt_q%0d", qv[k]), 32'(g), 32'(eg));
      chk($sformatf("se_q%0d", qv[k]), 32'(s), 32'(m_se[k]));
      chk($sformatf("en_q%0d", qv[k]), 32'(e), 32'(m_own[k] >= 0));
      chk($sformatf("y_q%0d", qv[k]), 32'(yy), 32'(ey));
      chk($sformatf("onehot_q%0d", qv[k]), 32'($countones(g) <= 1), 32'd1);
    end
  endtask

  task automatic drive(input logic [3:0] r);
    if4.req = r; if1.req = r;
    if4.a = dv[0]; if4.b = dv[1]; if4.c = dv[2]; if4.d = dv[3];
    if1.a = dv[0]; if1.b = dv[1]; if1.c = dv[2]; if1.d = dv[3];
  endtask

  task automatic step(input logic [3:0] r);
    drive(r);
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    qv[0] = 4;
    qv[1] = 1;
    for (int i = 0; i < 4; i++) dv[i] = 3'(i);
    rst = 1'b1;
    drive(4'b0000);
    model_reset();

    // reset, idle, first grant
    do_reset();
    step(4'b0000);
    step(4'b0101);
    chk("r027_gnt", 32'(if4.gnt), 32'h1);
    chk("r027_y", 32'(if4.y), 32'h0);

    // full load rotation with quantum 4
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b1111);
      chk("r028_se", 32'(if4.se), 32'((i / 4) % 4));
      chk("r028_y", 32'(if4.y), 32'((i / 4) % 4));
    end

    // owner release hands over without a gap, then idle
    do_reset();
    step(4'b0010);
    step(4'b1010);
    step(4'b1000);
    chk("r029_gnt", 32'(if4.gnt), 32'h8);
    chk("r029_y", 32'(if4.y), 32'h3);
    step(4'b0000);
    chk("r029_idle", 32'(if4.gnt), 32'h0);
    chk("r029_en", 32'(if4.en), 32'h0);

    // lone requester past quantum keeps the grant
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0100);
      chk("r030_gnt", 32'(if4.gnt), 32'h4);
    end

    // async reset during a d grant
    do_reset();
    for (int i = 0; i < 13; i++) step(4'b1111);
    chk("r031_se_d", 32'(if4.se), 32'h3);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("r031_gnt", 32'(if4.gnt), 32'h0);
    chk("r031_en", 32'(if4.en), 32'h0);
    chk("r031_y", 32'(if4.y), 32'h0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111);
    chk("r031_first", 32'(if4.gnt), 32'h1);

    // quantum 1 strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b0011);
      chk("r032_gnt", 32'(if1.gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // random traffic with occasional reset pulses
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      for (int j = 0; j < 4; j++) dv[j] = 3'($urandom_range(0, 7));
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter: QUANTUM, default 4, maximum consecutive grant cycles per owner while others wait; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request lines; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-005 a, b, c, d  input  3 each  requester data words.
REQ-006 gnt  output  4  registered one-hot grant, or 0000 when idle.
REQ-007 se  output  2  registered select index of current owner: a=00, b=01, c=10, d=11.
REQ-008 en  output  1  registered; 1 exactly when gnt is nonzero.
REQ-009 y  output  3  shared datapath output: data of owner selected by se when en=1, else 000; combinational from se/en and data inputs.

Function
REQ-010 States SHALL be IDLE (no owner) and GRANT (one owner); internal regs ptr[1:0] (highest-priority index) and cnt[3:0].
REQ-011 Arbitration SHALL scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first with req set.
REQ-012 IDLE, any req set: next edge -> GRANT, gnt/se = winner, en=1, cnt=1.
REQ-013 IDLE, req=0000: remain IDLE, outputs unchanged at gnt=0000, en=0, se held.
REQ-014 GRANT, req[se]=1 and cnt<QUANTUM: hold owner, cnt+1.
REQ-015 GRANT, req[se]=0: ptr <= se+1 (mod 4); arbitrate with owner excluded; winner granted next edge with cnt=1 (no idle gap); no winner -> IDLE, gnt=0000, en=0.
REQ-016 GRANT, req[se]=1 and cnt=QUANTUM: ptr <= se+1 (mod 4); arbitrate from new ptr; if owner is sole requester it re-wins with cnt=1.
REQ-017 Grant decisions SHALL be registered: request change in cycle N is reflected on gnt/se/en in cycle N+1; y follows in same cycle as se/en.
REQ-018 gnt SHALL never have more than one bit set; se SHALL always equal index of set gnt bit when en=1.
REQ-019 Simultaneous requests SHALL be resolved solely by ptr order; arrival order is ignored.
REQ-020 ptr wrap-around: se=11 releasing SHALL set ptr=00.
REQ-021 cnt SHALL never exceed QUANTUM; QUANTUM=1 yields strict per-cycle rotation among active requesters.

Reset
REQ-022 rst=1 SHALL immediately, independent of clk, force IDLE, gnt=0000, se=00, en=0, ptr=00, cnt=0; y therefore 000.
REQ-023 Reset asserted mid-grant SHALL abort the grant; after release, first arbitration starts from ptr=00.
REQ-024 First state change after rst deassertion SHALL occur on the first rising clk edge with rst=0.

Structure
REQ-025 Shared package SHALL hold state encoding (IDLE, GRANT), requester index constants (A=00..D=11), data width 3, requester count 4.
REQ-026 One sub-module rr_pick SHALL implement combinational rotate-priority selection (inputs req, ptr, exclude mask; outputs found, index); FSM, counter and output mux stay in top.

Verification
REQ-027 Reset then req=0101 at cycle 1 -> cycle 2 gnt=0001, se=00, en=1, y=a; with a=000,b=001,c=010,d=011 y=000.
REQ-028 req=1111 held, QUANTUM=4 -> owners a,b,c,d each 4 cycles in order, then a again; y steps 000,001,010,011.
REQ-029 Owner b drops req while req=1010 -> next cycle gnt=1000, se=11, y=011, no idle cycle; then req=0000 -> gnt=0000, en=0, y=000.
REQ-030 Only c requesting past quantum -> gnt stays 0100 continuously, cnt restarts at 1 every 4 cycles.
REQ-031 Async rst pulse mid-cycle during d grant -> gnt=0000, en=0, y=000 before next edge; after release with req=1111 first grant is a.
REQ-032 QUANTUM=1, req=0011 -> gnt alternates 0001/0010 every cycle; one-hot and se/gnt consistency asserted throughout.
